// File: rtl/mult_pkg.sv
// Shared types and default sizing for the hex multiplier sequencing logic.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } mult_seq_state_t;

    localparam int DEF_NUM_STEPS = 6;
    localparam int DEF_ADD_STEPS = 5;
    localparam int DEF_MUX_STEPS = 4;

endpackage

// File: rtl/mult_step_cnt.sv
// Step counter with clear > load-to-one > increment > hold priority.
// The next count is exported so the controller can decode registered strobes from it.
module mult_step_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic [W-1:0] cnt_nxt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // NOTE: every signal driven from always_comb gets a default first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = W'(1);
        end else if (inc_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencing controller for the multiplier datapath: runs NUM_STEPS steps and opens
// adder/mux enable windows, with pause on enable, synchronous abort and back-to-back restart.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int NUM_STEPS = DEF_NUM_STEPS,
    parameter int ADD_STEPS = DEF_ADD_STEPS,
    parameter int MUX_STEPS = DEF_MUX_STEPS,
    parameter int STEP_W    = $clog2(NUM_STEPS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              enable,
    input  logic              abort,
    output logic              busy,
    output logic [STEP_W-1:0] step,
    output logic              adder_en,
    output logic              mux_en,
    output logic              done,
    output logic              err_start
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS);
    localparam logic [STEP_W-1:0] ADD_LAST  = STEP_W'(ADD_STEPS);
    localparam logic [STEP_W-1:0] MUX_LAST  = STEP_W'(MUX_STEPS);

    mult_seq_state_t   state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              cnt_clr, cnt_load, cnt_inc;
    logic              err_d;
    logic              busy_q, adder_q, mux_q, done_q, err_q;

    mult_step_cnt #(.W(STEP_W)) u_step_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (cnt_clr),
        .load_i    (cnt_load),
        .inc_i     (cnt_inc),
        .cnt_o     (step_q),
        .cnt_nxt_o (step_d)
    );

    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        err_d    = 1'b0;
        if (abort) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && enable) begin
                        state_d  = RUN;
                        cnt_load = 1'b1;
                    end else begin
                        cnt_clr = 1'b1;
                    end
                end
                RUN: begin
                    if (step_q < LAST_STEP) begin
                        err_d = start;
                        if (enable) begin
                            cnt_inc = 1'b1;
                        end else begin
                            state_d = HOLD;
                        end
                    end else if (start && enable) begin
                        cnt_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_clr = 1'b1;
                    end
                end
                HOLD: begin
                    // The paused step already executed, so resuming moves straight to the next one.
                    err_d = start;
                    if (enable) begin
                        state_d = RUN;
                        cnt_inc = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    // Strobes decode the next state/step so they line up with the registered step value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            adder_q <= 1'b0;
            mux_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            adder_q <= (state_d == RUN) && (step_d != '0) && (step_d <= ADD_LAST);
            mux_q   <= (state_d == RUN) && (step_d != '0) && (step_d <= MUX_LAST);
            done_q  <= (state_d == RUN) && (step_d == LAST_STEP);
            err_q   <= err_d;
        end
    end

    assign busy      = busy_q;
    assign step      = step_q;
    assign adder_en  = adder_q;
    assign mux_en    = mux_q;
    assign done      = done_q;
    assign err_start = err_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: a 6/5/4 instance and a 2/1/1 instance, each with a
// behavioural model feeding a scoreboard, plus per-scenario inline checks.
module tb_mult_seq_ctrl;

    localparam int N1 = 6, A1 = 5, M1 = 4;
    localparam int N2 = 2, A2 = 1, M2 = 1;
    localparam int W1 = $clog2(N1 + 1);
    localparam int W2 = $clog2(N2 + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start1 = 1'b0, enable1 = 1'b0, abort1 = 1'b0;
    logic start2 = 1'b0, enable2 = 1'b0, abort2 = 1'b0;
    logic busy1, adder1, mux1, done1, err1;
    logic busy2, adder2, mux2, done2, err2;
    logic [W1-1:0] step1;
    logic [W2-1:0] step2;

    always #5 clk = ~clk;

    mult_seq_ctrl #(.NUM_STEPS(N1), .ADD_STEPS(A1), .MUX_STEPS(M1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start1), .enable(enable1), .abort(abort1),
        .busy(busy1), .step(step1), .adder_en(adder1), .mux_en(mux1),
        .done(done1), .err_start(err1)
    );

    mult_seq_ctrl #(.NUM_STEPS(N2), .ADD_STEPS(A2), .MUX_STEPS(M2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .enable(enable2), .abort(abort2),
        .busy(busy2), .step(step2), .adder_en(adder2), .mux_en(mux2),
        .done(done2), .err_start(err2)
    );

    // st: 0 idle, 1 run, 2 hold
    typedef struct { int st; int step; } mstate_t;
    typedef struct { bit busy; int step; bit adder; bit mux; bit done; bit err; } exp_t;

    exp_t    q1[$], q2[$];
    mstate_t m1 = '{0, 0}, m2 = '{0, 0};
    int      n_checks = 0;
    int      n_fail = 0;

    function automatic void model(input int n, input int a, input int m, input mstate_t cur,
                                  input bit s, input bit e, input bit ab,
                                  output mstate_t nxt, output exp_t ex);
        bit run;
        nxt    = cur;
        ex.err = 1'b0;
        if (ab) begin
            nxt.st = 0; nxt.step = 0;
        end else if (cur.st == 0) begin
            if (s && e) begin nxt.st = 1; nxt.step = 1; end
        end else if (cur.st == 1 && cur.step < n) begin
            ex.err = s;
            if (e) nxt.step = cur.step + 1;
            else   nxt.st = 2;
        end else if (cur.st == 1) begin
            if (s && e) nxt.step = 1;
            else begin nxt.st = 0; nxt.step = 0; end
        end else begin
            ex.err = s;
            if (e) begin nxt.st = 1; nxt.step = cur.step + 1; end
        end
        run      = (nxt.st == 1);
        ex.busy  = (nxt.st != 0);
        ex.step  = nxt.step;
        ex.adder = run && nxt.step >= 1 && nxt.step <= a;
        ex.mux   = run && nxt.step >= 1 && nxt.step <= m;
        ex.done  = run && nxt.step == n;
    endfunction

    // Scoreboard: pop one expectation per DUT per clock, sampled just after the edge.
    exp_t       e1, e2;
    logic [11:0] act_v, exp_v;
    always begin
        @(posedge clk);
        #1;
        if (q1.size() > 0) begin
            e1    = q1.pop_front();
            act_v = {busy1, 8'(step1), adder1, mux1, done1, err1};
            exp_v = {e1.busy, 8'(e1.step), e1.adder, e1.mux, e1.done, e1.err};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL sb_main t=%0t {busy,step,add,mux,done,err} got=%h exp=%h", $time, act_v, exp_v);
            end
        end
        if (q2.size() > 0) begin
            e2    = q2.pop_front();
            act_v = {busy2, 8'(step2), adder2, mux2, done2, err2};
            exp_v = {e2.busy, 8'(e2.step), e2.adder, e2.mux, e2.done, e2.err};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL sb_two_step t=%0t {busy,step,add,mux,done,err} got=%h exp=%h", $time, act_v, exp_v);
            end
        end
    end

    task automatic drive(input bit s, input bit e, input bit ab,
                         input bit s2, input bit e2_in, input bit ab2);
        mstate_t n;
        exp_t    x;
        start1 = s;  enable1 = e;     abort1 = ab;
        start2 = s2; enable2 = e2_in; abort2 = ab2;
        model(N1, A1, M1, m1, s, e, ab, n, x);
        m1 = n; q1.push_back(x);
        model(N2, A2, M2, m2, s2, e2_in, ab2, n, x);
        m2 = n; q2.push_back(x);
        @(posedge clk);
        #2;
    endtask

    task automatic d1(input bit s, input bit e, input bit ab);
        drive(s, e, ab, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic d2(input bit s, input bit e, input bit ab);
        drive(1'b0, 1'b0, 1'b0, s, e, ab);
    endtask

    task automatic test_reset;
        #12;
        n_checks++;
        if ({busy1, step1, adder1, mux1, done1, err1} !== '0) begin
            n_fail++;
            $display("FAIL reset_main got busy=%b step=%0d add=%b mux=%b done=%b err=%b exp all 0",
                     busy1, step1, adder1, mux1, done1, err1);
        end
        n_checks++;
        if ({busy2, step2, adder2, mux2, done2, err2} !== '0) begin
            n_fail++;
            $display("FAIL reset_two_step got busy=%b step=%0d exp all 0", busy2, step2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic test_single;
        int steps[7];
        int exp_steps[7] = '{1, 2, 3, 4, 5, 6, 0};
        int n_add = 0, n_mux = 0, done_idx = -1;
        for (int i = 0; i < 7; i++) begin
            d1(i == 0, 1'b1, 1'b0);
            steps[i] = int'(step1);
            if (adder1) n_add++;
            if (mux1) n_mux++;
            if (done1) done_idx = i;
        end
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (steps[i] !== exp_steps[i]) begin
                n_fail++;
                $display("FAIL single_step[%0d] got=%0d exp=%0d", i, steps[i], exp_steps[i]);
            end
        end
        n_checks++;
        if (n_add !== 5 || n_mux !== 4 || done_idx !== 5) begin
            n_fail++;
            $display("FAIL single_windows got add=%0d mux=%0d done_idx=%0d exp 5 4 5", n_add, n_mux, done_idx);
        end
    endtask

    task automatic test_pause;
        bit en_tab[10] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
        int done_idx = -1, n_hold = 0;
        for (int i = 0; i < 10; i++) begin
            d1(i == 0, en_tab[i], 1'b0);
            if (done1) done_idx = i;
            if (busy1 && step1 == 3 && !adder1 && !mux1 && !done1) n_hold++;
        end
        n_checks++;
        if (done_idx !== 8 || n_hold !== 3) begin
            n_fail++;
            $display("FAIL pause_timing got done_idx=%0d hold_cycles=%0d exp 8 3", done_idx, n_hold);
        end
    endtask

    task automatic test_back_to_back;
        int n_done = 0, n_zero = 0, step_after_wrap = -1;
        for (int i = 0; i < 12; i++) begin
            d1(1'b1, 1'b1, 1'b0);
            if (done1) n_done++;
            if (step1 == 0) n_zero++;
            if (i == 6) step_after_wrap = int'(step1);
        end
        d1(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (n_done !== 2 || n_zero !== 0 || step_after_wrap !== 1) begin
            n_fail++;
            $display("FAIL back_to_back got done=%0d idle=%0d wrap_step=%0d exp 2 0 1",
                     n_done, n_zero, step_after_wrap);
        end
    endtask

    task automatic test_abort;
        int n_done = 0;
        for (int i = 0; i < 5; i++) begin
            d1(i == 0, 1'b1, 1'b0);
            if (done1) n_done++;
        end
        d1(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (busy1 !== 1'b0 || step1 !== '0) begin
            n_fail++;
            $display("FAIL abort_idle got busy=%b step=%0d exp 0 0", busy1, step1);
        end
        for (int i = 0; i < 3; i++) begin
            d1(1'b0, 1'b1, 1'b0);
            if (done1) n_done++;
        end
        n_checks++;
        if (n_done !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done got=%0d exp=0", n_done);
        end
        d1(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_beats_start got busy=%b exp 0", busy1);
        end
        d1(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (busy1 !== 1'b0 || err1 !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_start_no_enable got busy=%b err=%b exp 0 0", busy1, err1);
        end
    endtask

    task automatic test_err_start;
        bit s_run[7]  = '{1, 0, 1, 0, 0, 0, 0};
        bit s_hold[8] = '{1, 0, 0, 1, 0, 0, 0, 0};
        bit e_hold[8] = '{1, 1, 0, 0, 1, 1, 1, 1};
        int n_err = 0, n_done = 0, resume_step = -1;
        for (int i = 0; i < 7; i++) begin
            d1(s_run[i], 1'b1, 1'b0);
            if (err1) n_err++;
            if (done1) n_done++;
        end
        n_checks++;
        if (n_err !== 1 || n_done !== 1) begin
            n_fail++;
            $display("FAIL err_in_run got err=%0d done=%0d exp 1 1", n_err, n_done);
        end
        n_err = 0; n_done = 0;
        for (int i = 0; i < 8; i++) begin
            d1(s_hold[i], e_hold[i], 1'b0);
            if (err1) n_err++;
            if (done1) n_done++;
            if (i == 4) resume_step = int'(step1);
        end
        n_checks++;
        if (n_err !== 1 || n_done !== 1 || resume_step !== 3) begin
            n_fail++;
            $display("FAIL err_in_hold got err=%0d done=%0d resume=%0d exp 1 1 3", n_err, n_done, resume_step);
        end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 4; i++) d1(i == 0, 1'b1, 1'b0);
        n_checks++;
        if (step1 !== W1'(4)) begin
            n_fail++;
            $display("FAIL async_pre_step got=%0d exp=4", step1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy1, step1, adder1, mux1, done1, err1} !== '0) begin
            n_fail++;
            $display("FAIL async_clear got busy=%b step=%0d add=%b mux=%b done=%b err=%b exp all 0",
                     busy1, step1, adder1, mux1, done1, err1);
        end
        m1 = '{0, 0};
        m2 = '{0, 0};
        start1 = 1'b0; enable1 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) d1(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0) begin
            n_fail++;
            $display("FAIL async_after_release got busy=%b done=%b exp 0 0", busy1, done1);
        end
    endtask

    task automatic test_two_step;
        int steps[3];
        int exp_steps[3] = '{1, 2, 0};
        int n_done = 0;
        for (int i = 0; i < 3; i++) begin
            d2(i == 0, 1'b1, 1'b0);
            steps[i] = int'(step2);
            if (done2) n_done++;
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (steps[i] !== exp_steps[i]) begin
                n_fail++;
                $display("FAIL two_step[%0d] got=%0d exp=%0d", i, steps[i], exp_steps[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            d2(1'b1, 1'b1, 1'b0);
            if (done2) n_done++;
        end
        d2(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (n_done !== 3) begin
            n_fail++;
            $display("FAIL two_step_done got=%0d exp=3", n_done);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_pause();
        test_back_to_back();
        test_abort();
        test_err_start();
        test_async_reset();
        test_two_step();
        @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Parametrised sequencing controller for the hex multiplier datapath.
- Runs a programmable-length compute sequence and drives adder_en/mux_en windows with a one-cycle done strobe.
- Adds three behaviours: pause/resume on enable, synchronous abort, and back-to-back restart.
- Sits between the top-level control FSM and the adder/mux datapath.

Parameters:
- NUM_STEPS, 6: compute steps per operation; must be >= 2.
- ADD_STEPS, 5: adder_en is high during steps 1..ADD_STEPS; requires ADD_STEPS <= NUM_STEPS.
- MUX_STEPS, 4: mux_en is high during steps 1..MUX_STEPS; requires MUX_STEPS <= ADD_STEPS.
- STEP_W, $clog2(NUM_STEPS+1): step counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level request, sampled in IDLE and in the last step
- enable  in  1  run permission; low pauses the sequence
- abort  in  1  synchronous cancel, highest priority after reset
- busy  out  1  high in RUN or HOLD
- step  out  STEP_W  current step; 0 in IDLE
- adder_en  out  1  adder enable strobe
- mux_en  out  1  mux select enable
- done  out  1  one-cycle completion pulse
- err_start  out  1  one-cycle pulse when start is ignored

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. Reset forces state=IDLE, step=0, and busy, adder_en, mux_en, done, err_start all 0.
- Outputs are registered. Each is a decode of the registered state/step, computed from next-state so it is valid in the same cycle as step.
- States: IDLE, RUN, HOLD.
- Decode in RUN:
  - adder_en = (1 <= step <= ADD_STEPS)
  - mux_en = (1 <= step <= MUX_STEPS)
  - done = (step == NUM_STEPS)
- In IDLE and HOLD, adder_en, mux_en and done are all 0.
- IDLE:
  - start=1 and enable=1 -> RUN, step=1. Latency: strobes are high in the cycle after start is sampled.
  - Otherwise stay in IDLE.
- RUN, step k < NUM_STEPS:
  - enable=1 -> RUN, step=k+1.
  - enable=0 -> HOLD, step=k. Step k counts as executed.
- RUN, step == NUM_STEPS (done=1 this cycle):
  - start=1 and enable=1 -> RUN, step=1 (back-to-back, no IDLE bubble).
  - Otherwise -> IDLE, step=0.
- HOLD:
  - enable=1 -> RUN, step=k+1.
  - enable=0 -> stay in HOLD. The paused step is never re-executed.
- abort=1 in any state -> next cycle IDLE, step=0, no done. abort beats start and enable in the same cycle.
- err_start pulses for one cycle when start=1 in RUN with step < NUM_STEPS, or in HOLD. The request is dropped and the sequence is unaffected.
- In IDLE, start=1 with enable=0 is ignored with no error.
- Reset mid-operation: outputs clear immediately (asynchronous); no done is produced.
- Counter arithmetic: step never exceeds NUM_STEPS, so there is no wrap-around. Unreachable state encodings recover to IDLE.

Decomposition:
- Shared package mult_pkg holds:
  - state enum typedef mult_seq_state_t {IDLE, RUN, HOLD}
  - default NUM_STEPS/ADD_STEPS/MUX_STEPS constants
- Optional sub-module mult_step_cnt: loadable up-counter with inc/hold/clear, STEP_W wide.
- Everything else lives in a single module.

Test Plan (defaults 6/5/4):
1. start=1 for one cycle in IDLE, enable=1 held:
   - next 6 cycles step=1..6
   - adder_en high on steps 1-5, mux_en on steps 1-4, done only on step 6
   - then IDLE, step=0
2. Drop enable for 3 cycles while step=3:
   - HOLD with step=3 for 3 cycles, all strobes 0
   - resume at step=4
   - done appears 3 cycles later than in scenario 1
3. start=1 held continuously:
   - step sequence 1..6,1..6 with no idle cycle
   - done pulses on each step 6
4. abort at step=5:
   - next cycle IDLE, step=0, busy=0, done never asserted
   - abort and start together in IDLE -> stays IDLE
5. start pulse at step=2:
   - err_start=1 for one cycle, sequence completes normally
   - start at step=2 during HOLD -> err_start=1, sequence unaffected
6. Assert rst_n=0 asynchronously at step=4:
   - all outputs 0 before the next clk edge
   - after release, IDLE until start
   - repeat with NUM_STEPS=2, ADD=MUX=1 to confirm a 2-step sequence
